// File: rtl/fft_spectrum_overlay_if.sv
// rtl/fft_spectrum_overlay_if.sv - video, magnitude-write and control bundle of the spectrum overlay
interface fft_spectrum_overlay_if #(
  parameter int NBINS = 512,
  parameter int MAG_W = 9
);
  localparam int AW = $clog2(NBINS);

  logic             i_hs;
  logic             i_vs;
  logic             i_de;
  logic [23:0]      i_data;
  logic             o_hs;
  logic             o_vs;
  logic             o_de;
  logic [23:0]      o_data;
  logic             bin_wr_en;
  logic [AW-1:0]    bin_wr_addr;
  logic [MAG_W-1:0] bin_wr_data;
  logic             bin_frame_done;
  logic [1:0]       mode;
  logic             sweep_overrun;

  modport master (
    output i_hs, i_vs, i_de, i_data, bin_wr_en, bin_wr_addr, bin_wr_data, bin_frame_done, mode,
    input  o_hs, o_vs, o_de, o_data, sweep_overrun
  );

  modport slave (
    input  i_hs, i_vs, i_de, i_data, bin_wr_en, bin_wr_addr, bin_wr_data, bin_frame_done, mode,
    output o_hs, o_vs, o_de, o_data, sweep_overrun
  );
endinterface

// File: rtl/fft_spectrum_overlay.sv
// rtl/fft_spectrum_overlay.sv - spectrum bar/peak overlay on a video stream, ping-pong magnitude banks
module fft_spectrum_overlay #(
  parameter int X0       = 453,
  parameter int Y0       = 670,
  parameter int NBINS    = 512,
  parameter int BAR_W    = 2,
  parameter int HEIGHT   = 256,
  parameter int MAG_W    = 9,
  parameter int SHIFT    = 1,
  parameter int GRID_DIV = 5,
  parameter int DECAY    = 2
) (
  input logic pclk,
  input logic rst_n,
  fft_spectrum_overlay_if.slave bus
);
  localparam int AW        = $clog2(NBINS);
  localparam int PW        = $clog2(HEIGHT + 1);
  localparam int X1        = X0 + NBINS * BAR_W;
  localparam int Y1        = Y0 + HEIGHT;
  localparam int CW        = $clog2(X1 + Y1 + 1) + 1;
  localparam int GRID_STEP = HEIGHT / GRID_DIV;
  localparam int RED_ROW   = HEIGHT * 3 / 4;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] GREEN = 24'h00CC00;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREY  = 24'h404040;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    idx, idx_nxt;
  logic             sweep_wr;

  logic [MAG_W-1:0] bank0 [NBINS];
  logic [MAG_W-1:0] bank1 [NBINS];
  logic [PW-1:0]    peak  [NBINS];

  logic             vs_q, de_q, front_sel, swap_pending, start_q, overrun, clr_active;
  logic [AW-1:0]    clr_addr;
  logic [1:0]       mode_q;
  logic [CW-1:0]    x_cnt, y_cnt, cur_x, dx;
  logic             vs_rise, de_rise, de_fall, swap_now, wr_bank, in_region;
  logic [AW-1:0]    bin_c;
  logic [PW-1:0]    row_c;

  logic             s1_hs, s1_vs, s1_de, s1_in;
  logic [23:0]      s1_data, pix;
  logic [AW-1:0]    s1_bin;
  logic [PW-1:0]    s1_row;
  logic [MAG_W-1:0] disp_mag, sw_mag;
  logic [PW-1:0]    disp_pk, disp_h, sw_old, sw_dec, sw_bar, sw_new;

  // Bar height with saturation at the plot height; computed wide so large magnitudes never wrap.
  function automatic logic [PW-1:0] bar_h(input logic [MAG_W-1:0] m);
    logic [31:0] s;
    s = 32'(m) >> SHIFT;
    if (s >= 32'(HEIGHT)) return PW'(HEIGHT);
    return PW'(s);
  endfunction

  assign vs_rise   = bus.i_vs & ~vs_q;
  assign de_rise   = bus.i_de & ~de_q;
  assign de_fall   = ~bus.i_de & de_q;
  assign swap_now  = vs_rise & swap_pending;
  // During the swap cycle the old front is already the new back bank.
  assign wr_bank   = swap_now ? front_sel : ~front_sel;
  assign cur_x     = de_rise ? '0 : x_cnt;
  assign in_region = bus.i_de && (cur_x >= CW'(X0)) && (cur_x < CW'(X1)) &&
                     (y_cnt >= CW'(Y0)) && (y_cnt < CW'(Y1));
  assign dx        = cur_x - CW'(X0);
  assign bin_c     = AW'(dx / CW'(BAR_W));
  assign row_c     = PW'(CW'(Y1 - 1) - y_cnt);
  assign bus.sweep_overrun = overrun;

  assign disp_mag = front_sel ? bank1[s1_bin] : bank0[s1_bin];
  assign disp_pk  = peak[s1_bin];
  assign disp_h   = bar_h(disp_mag);

  assign sw_mag = front_sel ? bank1[idx] : bank0[idx];
  assign sw_old = peak[idx];
  assign sw_dec = (32'(sw_old) > 32'(DECAY)) ? sw_old - PW'(DECAY) : '0;
  assign sw_bar = bar_h(sw_mag);
  assign sw_new = (sw_bar > sw_dec) ? sw_bar : sw_dec;

  always_comb begin
    pix = s1_data;
    if (s1_in) begin
      if (mode_q[1] && disp_pk != '0 && s1_row == disp_pk)
        pix = WHITE;
      else if ((mode_q == 2'd1 || mode_q == 2'd2) && s1_row < disp_h)
        pix = (32'(s1_row) < 32'(RED_ROW)) ? GREEN : RED;
      else if (mode_q != 2'd0 && (32'(s1_row) % 32'(GRID_STEP)) == 32'd0)
        pix = GREY;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sweep_wr  = 1'b0;
    case (state)
      IDLE: if (start_q) begin
        state_nxt = SWEEP;
        idx_nxt   = '0;
      end
      SWEEP: begin
        sweep_wr = 1'b1;
        idx_nxt  = idx + 1'b1;
        if (idx == AW'(NBINS - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      mode_q       <= 2'd0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      start_q      <= 1'b0;
      overrun      <= 1'b0;
      clr_active   <= 1'b1;
      clr_addr     <= '0;
      s1_hs        <= 1'b0;
      s1_vs        <= 1'b0;
      s1_de        <= 1'b0;
      s1_in        <= 1'b0;
      s1_data      <= '0;
      s1_bin       <= '0;
      s1_row       <= '0;
      bus.o_hs     <= 1'b0;
      bus.o_vs     <= 1'b0;
      bus.o_de     <= 1'b0;
      bus.o_data   <= '0;
    end else begin
      vs_q <= bus.i_vs;
      de_q <= bus.i_de;
      if (bus.i_de) x_cnt <= cur_x + 1'b1;
      if (vs_rise) y_cnt <= '0;
      else if (de_fall) y_cnt <= y_cnt + 1'b1;
      if (vs_rise) mode_q <= bus.mode;
      if (swap_now) front_sel <= ~front_sel;
      // A done pulse in the swap cycle re-arms the flag for the next frame.
      swap_pending <= swap_now ? bus.bin_frame_done : (swap_pending | bus.bin_frame_done);
      start_q <= vs_rise & ~clr_active;
      if (de_rise && state == SWEEP) overrun <= 1'b1;
      if (clr_active) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == AW'(NBINS - 1)) clr_active <= 1'b0;
      end
      s1_hs      <= bus.i_hs;
      s1_vs      <= bus.i_vs;
      s1_de      <= bus.i_de;
      s1_data    <= bus.i_data;
      s1_in      <= in_region & ~clr_active;
      s1_bin     <= bin_c;
      s1_row     <= row_c;
      bus.o_hs   <= s1_hs;
      bus.o_vs   <= s1_vs;
      bus.o_de   <= s1_de;
      bus.o_data <= pix;
    end
  end

  always_ff @(posedge pclk) begin
    if (clr_active) begin
      bank0[clr_addr] <= '0;
      bank1[clr_addr] <= '0;
      peak[clr_addr]  <= '0;
    end
    if (bus.bin_wr_en) begin
      if (wr_bank) bank1[bus.bin_wr_addr] <= bus.bin_wr_data;
      else         bank0[bus.bin_wr_addr] <= bus.bin_wr_data;
    end
    if (sweep_wr) peak[idx] <= sw_new;
  end
endmodule

// File: tb/tb_fft_spectrum_overlay.sv
// tb/tb_fft_spectrum_overlay.sv - directed frame-level bench for fft_spectrum_overlay
module tb_fft_spectrum_overlay;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] GREEN = 24'h00CC00;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREY  = 24'h404040;

  logic pclk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  fft_spectrum_overlay_if #(.NBINS(8), .MAG_W(7)) bus ();

  fft_spectrum_overlay #(
    .X0(4), .Y0(2), .NBINS(8), .BAR_W(2), .HEIGHT(16), .MAG_W(7),
    .SHIFT(1), .GRID_DIV(4), .DECAY(2)
  ) dut (
    .pclk (pclk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output capture indexed by the output's own de/vs timing; 20 lines x 24 pixels per frame.
  logic [23:0] cap [20][24];
  int          ox = 0, oy = 0;
  bit          pde = 0, pvs = 0, byp_on = 0;
  logic [26:0] h1 = '0, h2 = '0;

  always @(negedge pclk) begin
    if (bus.o_vs && !pvs) oy = 0;
    if (bus.o_de) begin
      if (!pde) ox = 0;
      if (oy < 20 && ox < 24) cap[oy][ox] = bus.o_data;
      ox++;
    end else if (pde) oy++;
    pde = bus.o_de;
    pvs = bus.o_vs;
    if (byp_on) check("bypass", {5'd0, bus.o_hs, bus.o_vs, bus.o_de, bus.o_data}, {5'd0, h2});
    h2 = h1;
    h1 = {bus.i_hs, bus.i_vs, bus.i_de, bus.i_data};
  end

  function automatic logic [23:0] pt(input int x, input int y);
    return {8'h5A, 8'(x), 8'(y)};
  endfunction

  function automatic logic [23:0] px(input int x, input int row);
    return cap[17 - row][x];
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    bus.bin_wr_en = 1'b1;
    bus.bin_wr_addr = 3'(a);
    bus.bin_wr_data = 7'(d);
    step();
    bus.bin_wr_en = 1'b0;
  endtask

  task automatic frame(input int vs_len, input int vb_len, input bit rnd, input bit done_at_vs,
                       input bit wr_at_vs, input int wa, input int wd);
    for (int c = 0; c < vs_len + vb_len; c++) begin
      bus.i_vs = (c < vs_len);
      bus.i_de = 1'b0;
      bus.i_hs = 1'b0;
      bus.i_data = rnd ? 24'($urandom) : 24'h0;
      bus.bin_frame_done = (c == 0) && done_at_vs;
      bus.bin_wr_en = (c == 0) && wr_at_vs;
      bus.bin_wr_addr = 3'(wa);
      bus.bin_wr_data = 7'(wd);
      step();
    end
    bus.bin_frame_done = 1'b0;
    bus.bin_wr_en = 1'b0;
    for (int ln = 0; ln < 20; ln++) begin
      for (int c = 0; c < 28; c++) begin
        bus.i_vs = 1'b0;
        bus.i_de = (c < 24);
        bus.i_hs = (c == 24 || c == 25);
        bus.i_data = rnd ? 24'($urandom) : pt(c, ln);
        step();
      end
    end
    bus.i_data = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_hs = 1'b1; bus.i_vs = 1'b1; bus.i_de = 1'b1; bus.i_data = 24'hFFFFFF;
    bus.bin_wr_en = 1'b0; bus.bin_wr_addr = '0; bus.bin_wr_data = '0;
    bus.bin_frame_done = 1'b0; bus.mode = 2'd0;
    repeat (3) step();
    check("rst_outputs", {4'd0, bus.o_hs, bus.o_vs, bus.o_de, bus.sweep_overrun, bus.o_data}, 32'd0);
    bus.i_hs = 1'b0; bus.i_vs = 1'b0; bus.i_de = 1'b0; bus.i_data = '0;
    step();
    rst_n = 1'b1;
    repeat (12) step();

    wr(1, 20); wr(3, 70); wr(5, 30);
    bus.bin_frame_done = 1'b1; step(); bus.bin_frame_done = 1'b0;
    repeat (4) step();

    // A: bypass with random video; swap to bank1, bin2 written in the swap cycle
    byp_on = 1;
    frame(6, 22, 1, 0, 1, 2, 16);
    byp_on = 0;

    // B: bars from bank1
    bus.mode = 2'd1;
    frame(6, 22, 0, 0, 0, 0, 0);
    check("B_bin1_r0",   32'(px(6, 0)),   32'(GREEN));
    check("B_bin1_r9",   32'(px(7, 9)),   32'(GREEN));
    check("B_bin1_r10",  32'(px(6, 10)),  32'(pt(6, 7)));
    check("B_bin1_grid", 32'(px(6, 12)),  32'(GREY));
    check("B_clamp_r15", 32'(px(10, 15)), 32'(RED));
    check("B_bin3_r12",  32'(px(11, 12)), 32'(RED));
    check("B_bin3_r11",  32'(px(11, 11)), 32'(GREEN));
    check("B_bin5_r14",  32'(px(14, 14)), 32'(RED));
    check("B_bin5_r15",  32'(px(15, 15)), 32'(pt(15, 2)));
    check("B_swapwr",    32'(px(8, 0)),   32'(GREY));
    check("B_bin2_r5",   32'(px(8, 5)),   32'(pt(8, 12)));
    check("B_left",      32'(px(3, 0)),   32'(pt(3, 17)));
    check("B_lastcol",   32'(px(19, 0)),  32'(GREY));
    check("B_right",     32'(px(20, 0)),  32'(pt(20, 17)));
    check("B_above",     32'(cap[1][10]), 32'(pt(10, 1)));
    check("B_below",     32'(cap[18][10]), 32'(pt(10, 18)));

    // C: frame_done coincides with vs rise, so the front bank stays bank1
    bus.mode = 2'd2;
    frame(6, 22, 0, 1, 0, 0, 0);
    check("C_noswap",    32'(px(8, 0)),   32'(GREY));
    check("C_mark1",     32'(px(6, 10)),  32'(WHITE));
    check("C_bar1",      32'(px(6, 9)),   32'(GREEN));
    check("C_mark5",     32'(px(14, 15)), 32'(WHITE));
    check("C_bin3_r15",  32'(px(10, 15)), 32'(RED));

    // D: deferred swap to bank0, peak-only mode
    bus.mode = 2'd3;
    frame(6, 22, 0, 0, 0, 0, 0);
    check("D_mark2",     32'(px(8, 8)),   32'(WHITE));
    check("D_nobar",     32'(px(9, 1)),   32'(pt(9, 16)));
    check("D_grid",      32'(px(8, 4)),   32'(GREY));
    check("D_mark1",     32'(px(6, 8)),   32'(WHITE));
    check("D_old1",      32'(px(6, 10)),  32'(pt(6, 7)));
    check("D_mark3",     32'(px(10, 14)), 32'(WHITE));
    check("D_mark5",     32'(px(14, 13)), 32'(WHITE));

    // E..H: peaks decay by 2 per frame
    bus.mode = 2'd2;
    frame(6, 22, 0, 0, 0, 0, 0);
    check("E_mark1",     32'(px(6, 6)),   32'(WHITE));
    check("E_nobar1",    32'(px(6, 5)),   32'(pt(6, 12)));
    check("E_mark2",     32'(px(8, 8)),   32'(WHITE));
    check("E_bar2",      32'(px(8, 7)),   32'(GREEN));
    check("E_markgrid",  32'(px(10, 12)), 32'(WHITE));
    check("E_mark5",     32'(px(14, 11)), 32'(WHITE));
    frame(6, 22, 0, 0, 0, 0, 0);
    frame(6, 22, 0, 0, 0, 0, 0);
    check("G_mark1",     32'(px(6, 2)),   32'(WHITE));
    frame(6, 22, 0, 0, 0, 0, 0);
    check("H_zero_peak", 32'(px(6, 0)),   32'(GREY));
    check("H_gone",      32'(px(7, 2)),   32'(pt(7, 15)));
    check("H_mark3",     32'(px(10, 6)),  32'(WHITE));
    check("H_no_ovr",    32'(bus.sweep_overrun), 32'd0);

    // I: vblank shorter than the sweep
    frame(2, 2, 0, 0, 0, 0, 0);
    check("I_overrun",   32'(bus.sweep_overrun), 32'd1);
    repeat (50) step();
    check("I_held",      32'(bus.sweep_overrun), 32'd1);

    // Reset in the middle of a line
    bus.i_de = 1'b1; bus.i_data = 24'h123456;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {4'd0, bus.o_hs, bus.o_vs, bus.o_de, bus.sweep_overrun, bus.o_data}, 32'd0);
    bus.i_de = 1'b0; bus.i_data = '0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (12) step();
    bus.mode = 2'd1;
    frame(6, 22, 0, 0, 0, 0, 0);
    check("R_bank_clr",  32'(px(8, 1)),   32'(pt(8, 16)));
    check("R_grid",      32'(px(8, 0)),   32'(GREY));
    check("R_bin3_clr",  32'(px(10, 3)),  32'(pt(10, 14)));
    check("R_no_ovr",    32'(bus.sweep_overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_spectrum_overlay.md
FFT_SPECTRUM_OVERLAY -- requirements
Module: fft_spectrum_overlay

Interface
REQ-001 SHALL have parameter X0, default 453, meaning the left pixel column of the plot area.
REQ-002 SHALL have parameter Y0, default 670, meaning the top pixel row of the plot area.
REQ-003 SHALL have parameter NBINS, default 512, meaning the bin count (power of 2, 8..1024).
REQ-004 SHALL have parameter BAR_W, default 2, meaning the pixel width per bin (1..8).
REQ-005 SHALL have parameter HEIGHT, default 256, meaning the plot height in rows.
REQ-006 SHALL have parameter MAG_W, default 9, meaning the magnitude width.
REQ-007 SHALL have parameter SHIFT, default 1, meaning bar height = mag >> SHIFT.
REQ-008 SHALL have parameter GRID_DIV, default 5, meaning the number of horizontal grid intervals.
REQ-009 SHALL have parameter DECAY, default 2, meaning the per-frame peak decrement.
REQ-010 SHALL have ports pclk (in, 1, pixel clock) and rst_n (in, 1, asynchronous active-low reset); all logic SHALL be clocked on the pclk rising edge.
REQ-011 SHALL have ports i_hs, i_vs, i_de (in, 1 each, video timing; vs active high) and i_data (in, 24, RGB888).
REQ-012 SHALL have ports o_hs, o_vs, o_de (out, 1 each) and o_data (out, 24), the overlaid video.
REQ-013 SHALL have ports bin_wr_en (in, 1), bin_wr_addr (in, log2(NBINS)) and bin_wr_data (in, MAG_W), forming the magnitude write port.
REQ-014 SHALL have port bin_frame_done (in, 1), a one-cycle pulse indicating the back bank is complete.
REQ-015 SHALL have port mode (in, 2): 0 bypass, 1 bars, 2 bars+peak, 3 peak only.
REQ-016 SHALL have port sweep_overrun (out, 1), a sticky error flag.

Function
REQ-017 SHALL delay hs/vs/de/data by exactly 2 cycles in all modes; o_data SHALL equal the delayed i_data wherever no overlay pixel applies.
REQ-018 SHALL keep x/y counters: x clears on the de rising edge and increments while de is high; y increments on each de falling edge and clears on the vs rising edge.
REQ-019 SHALL use two magnitude banks, ping-pong; writes go to the back bank, and the display reads the front bank.
REQ-020 SHALL set swap_pending on bin_frame_done; at the vs rising edge, if swap_pending is set, the banks SHALL swap and swap_pending SHALL clear. A bin_frame_done coinciding with the vs rise SHALL defer its swap to the next frame.
REQ-021 SHALL implement the peak FSM states IDLE, SWEEP and DONE: IDLE->SWEEP one cycle after the vs rise (post-swap); SWEEP visits bins 0..NBINS-1 at one bin per cycle, setting peak[i] = max(sat0(peak[i]-DECAY), front[i]>>SHIFT clamped to HEIGHT); after the last bin the FSM SHALL go SWEEP->DONE->IDLE.
REQ-022 SHALL set sweep_overrun, which stays set until reset, if de rises while the FSM is in SWEEP; the sweep SHALL continue to completion regardless.
REQ-023 SHALL define the plot region as X0 <= x < X0+NBINS*BAR_W and Y0 <= y < Y0+HEIGHT; bin = (x-X0)/BAR_W, row = Y0+HEIGHT-1-y.
REQ-024 SHALL compute bar height h = min(front[bin]>>SHIFT, HEIGHT) with no wraparound.
REQ-025 SHALL resolve pixel priority inside the region: the peak marker (row == peak[bin], modes 2/3) 24'hFFFFFF; then the bar (row < h, modes 1/2) 24'h00CC00 if row < HEIGHT*3/4, else 24'hFF0000; then the grid (row multiple of HEIGHT/GRID_DIV, modes 1-3) 24'h404040; otherwise passthrough.
REQ-026 SHALL treat a peak value of 0 as no marker.
REQ-027 SHALL apply a mode change only at the vs rising edge.
REQ-028 SHALL accept back-bank writes on every cycle, including during a sweep or a swap cycle; a write in the swap cycle SHALL land in the new back bank.

Reset
REQ-029 SHALL, while rst_n is low, drive o_hs/o_vs/o_de = 0, o_data = 0 and sweep_overrun = 0, with the FSM in IDLE, swap_pending = 0, front = bank0 and the latched mode = 0.
REQ-030 SHALL clear all peaks and both banks to 0 by a post-reset NBINS-cycle clear sweep; the overlay is suppressed until this sweep completes.
REQ-031 SHALL restart from the REQ-029 state on reset assertion mid-sweep or mid-frame, with no partial swap.

Verification
REQ-032 SHALL pass: mode=0 with random video -> output equals input delayed by 2 cycles, bit-exact.
REQ-033 SHALL pass: bin 10 = 200, SHIFT=1, frame_done then vs -> bin 10 columns X0+20..X0+21 show green for rows 0..99, and the grid row at 51 stays green.
REQ-034 SHALL pass: mode=2, bin 3 = 400 then 0 -> peak at 200 (red bar top 192..199), then 198, 196 ... at one step per frame, reaching 0 after 100 frames with the marker gone.
REQ-035 SHALL pass: frame_done asserted on the same cycle as the vs rise -> no swap that frame, swap at the following vs.
REQ-036 SHALL pass: vblank shorter than NBINS cycles -> sweep_overrun = 1, held until reset.
REQ-037 SHALL pass: bin value 511 with HEIGHT=256 and SHIFT=0 -> bar clamped to full height, no wrap.
